led_breather: RTL

//  Upstream brightness sequencer for the LED PWM stage. Generates a "breathing"

---
 rtl/led_breather_pkg.sv | 20 ++
 rtl/led_prescaler.sv | 28 ++
 rtl/led_breather.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/led_breather_pkg.sv
// rtl/led_breather_pkg.sv - shared phase encodings and sizing helpers for the LED breathing sequencer
package led_breather_pkg;

    // Phase encodings are shared with the PWM stage for debug visibility.
    localparam int PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE    = 3'd0,
        PH_RISE    = 3'd1,
        PH_HOLD_HI = 3'd2,
        PH_FALL    = 3'd3,
        PH_HOLD_LO = 3'd4
    } phase_t;

    // Width of a counter that must reach ticks-1; never narrower than one bit.
    function automatic int hold_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running step prescaler with synchronous clear and all-ones tick
module led_prescaler #(
    parameter int PRESCALE_W = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [PRESCALE_W-1:0] count;

    // Count every clock; clear holds the counter at zero so the first tick
    // after a clear is always one full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // The counter wraps to zero on the same edge that consumes the tick.
    assign tick = &count;

endmodule

// File: rtl/led_breather.sv
// rtl/led_breather.sv - breathing duty-cycle ramp generator with valid/ready output to the PWM stage
module led_breather
    import led_breather_pkg::*;
#(
    parameter int BW         = 4,
    parameter int PRESCALE_W = 23,
    parameter int HOLD_TICKS = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_en,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [BW-1:0]       o_duty,
    output logic [PHASE_W-1:0]  o_phase,
    output logic                o_overrun
);

    localparam int              HW        = hold_width(HOLD_TICKS);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [BW-1:0]   DUTY_MAX  = {BW{1'b1}};
    localparam logic [BW-1:0]   DUTY_PEAK = DUTY_MAX - 1'b1;
    localparam logic [BW-1:0]   DUTY_ONE  = BW'(1);

    phase_t          state;
    logic [HW-1:0]   hold_cnt;
    logic            tick;
    logic            clr;
    logic            accept;
    logic            stall;

    // The prescaler idles at zero whenever the ramp is not running, so a
    // re-enable always waits one whole period before the first step.
    assign clr = (state == PH_IDLE) || !i_en;

    led_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (i_clk),
        .rst  (i_reset),
        .clr  (clr),
        .tick (tick)
    );

    // A tick is only dropped when the previous value is still unaccepted;
    // a handshake completing on the tick cycle frees the slot in time.
    assign accept = o_valid && i_ready;
    assign stall  = tick && o_valid && !i_ready;

    assign o_phase = state;

    // Ramp FSM, hold counter, duty register and output handshake.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= PH_IDLE;
            hold_cnt  <= '0;
            o_duty    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (accept) begin
                o_valid <= 1'b0;
            end

            if (!i_en) begin
                // Disable wins over any tick; the LED is forced dark and the
                // zero is offered downstream if it differs from what was sent
                // or replaces a value still waiting.
                if (state != PH_IDLE) begin
                    state    <= PH_IDLE;
                    hold_cnt <= '0;
                    o_duty   <= '0;
                    if ((o_duty != '0) || o_valid) begin
                        o_valid <= 1'b1;
                    end
                end
            end else begin
                unique case (state)
                    PH_IDLE: begin
                        state    <= PH_RISE;
                        hold_cnt <= '0;
                    end

                    PH_RISE: begin
                        if (tick) begin
                            if (stall) begin
                                o_overrun <= 1'b1;
                            end else begin
                                o_duty  <= o_duty + 1'b1;
                                o_valid <= 1'b1;
                                if (o_duty == DUTY_PEAK) begin
                                    state    <= PH_HOLD_HI;
                                    hold_cnt <= '0;
                                end
                            end
                        end
                    end

                    PH_HOLD_HI: begin
                        if (tick) begin
                            if (stall) begin
                                o_overrun <= 1'b1;
                            end else if (hold_cnt == HOLD_LAST) begin
                                state    <= PH_FALL;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end

                    PH_FALL: begin
                        if (tick) begin
                            if (stall) begin
                                o_overrun <= 1'b1;
                            end else begin
                                o_duty  <= o_duty - 1'b1;
                                o_valid <= 1'b1;
                                if (o_duty == DUTY_ONE) begin
                                    state    <= PH_HOLD_LO;
                                    hold_cnt <= '0;
                                end
                            end
                        end
                    end

                    PH_HOLD_LO: begin
                        if (tick) begin
                            if (stall) begin
                                o_overrun <= 1'b1;
                            end else if (hold_cnt == HOLD_LAST) begin
                                state    <= PH_RISE;
                                hold_cnt <= '0;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end

                    default: begin
                        state    <= PH_IDLE;
                        hold_cnt <= '0;
                        o_duty   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
